// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared key indices, key count and auto-repeat FSM state encoding
package tetris_pkg;

    localparam int NUM_KEYS  = 4;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    // Default auto-repeat enable: movement keys repeat, up/rotate does not.
    localparam logic [NUM_KEYS-1:0] REPEAT_MASK_DEFAULT =
        NUM_KEYS'((1 << KEY_DOWN) | (1 << KEY_LEFT) | (1 << KEY_RIGHT));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } key_state_e;

endpackage

// File: rtl/key_input_ctrl_if.sv
// rtl/key_input_ctrl_if.sv - button, frame-pulse and key-event bundle between board, VGA and grid controller
interface key_input_ctrl_if;
    import tetris_pkg::*;

    logic [NUM_KEYS-1:0] key_raw;
    logic                draw_finish;
    logic [NUM_KEYS-1:0] op_keys;
    logic [NUM_KEYS-1:0] key_level;

    // Environment side: drives buttons and frame pulse, observes events and levels.
    modport master (
        output key_raw,
        output draw_finish,
        input  op_keys,
        input  key_level
    );

    // Conditioning block side.
    modport slave (
        input  key_raw,
        input  draw_finish,
        output op_keys,
        output key_level
    );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser, stability counter, debounced level and rise pulse for one button
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain before anything looks at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing cycles; flip the level once the input has been stable long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
                rise  <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_input_ctrl.sv
// rtl/key_input_ctrl.sv - debounced key events with frame-paced auto-repeat (KEY_INPUT_AUTOREPEAT_EN) released on draw_finish
module key_input_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned         DEBOUNCE_CYCLES = 250000,
    parameter int unsigned         REPEAT_DELAY    = 20,
    parameter int unsigned         REPEAT_RATE     = 4,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = REPEAT_MASK_DEFAULT
) (
    input  logic             vga_clk,
    input  logic             reset,
    key_input_ctrl_if.slave  keys
);

    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] ev;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] op_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (vga_clk),
            .reset (reset),
            .raw   (keys.key_raw[k]),
            .level (level[k]),
            .rise  (rise[k])
        );
    end

    assign keys.key_level = level;
    assign keys.op_keys   = op_q;

`ifdef KEY_INPUT_AUTOREPEAT_EN

    localparam logic [7:0] DELAY_LOAD = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE_LOAD  = 8'(REPEAT_RATE);

    key_state_e state_q [NUM_KEYS];
    key_state_e state_d [NUM_KEYS];
    logic [7:0] frame_q [NUM_KEYS];
    logic [7:0] frame_d [NUM_KEYS];

    // Per-key repeat state and frame countdown registers.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= IDLE;
                frame_q[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                frame_q[k] <= frame_d[k];
            end
        end
    end

    // Press raises an event and arms the delay; each frame counts down; release always wins.
    always_comb begin
        ev = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            frame_d[k] = frame_q[k];
            case (state_q[k])
                IDLE: begin
                    if (rise[k]) begin
                        ev[k]      = 1'b1;
                        state_d[k] = DELAY;
                        frame_d[k] = DELAY_LOAD;
                    end
                end
                DELAY: begin
                    if (!level[k]) begin
                        state_d[k] = IDLE;
                        frame_d[k] = 8'd0;
                    end else if (REPEAT_MASK[k] && keys.draw_finish) begin
                        if (frame_q[k] == 8'd1) begin
                            ev[k]      = 1'b1;
                            state_d[k] = REPEAT;
                            frame_d[k] = RATE_LOAD;
                        end else begin
                            frame_d[k] = frame_q[k] - 8'd1;
                        end
                    end
                end
                REPEAT: begin
                    if (!level[k]) begin
                        state_d[k] = IDLE;
                        frame_d[k] = 8'd0;
                    end else if (keys.draw_finish) begin
                        if (frame_q[k] == 8'd1) begin
                            ev[k]      = 1'b1;
                            frame_d[k] = RATE_LOAD;
                        end else begin
                            frame_d[k] = frame_q[k] - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d[k] = IDLE;
                    frame_d[k] = 8'd0;
                end
            endcase
        end
    end

`else

    // Without auto-repeat only the debounced press edge produces an event.
    assign ev = rise;

    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE, REPEAT_MASK};

`endif

    // Collect events between frames and release them as a single-cycle pulse after draw_finish.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pending <= '0;
            op_q    <= '0;
        end else if (keys.draw_finish) begin
            op_q    <= pending | ev;
            pending <= '0;
        end else begin
            op_q    <= '0;
            pending <= pending | ev;
        end
    end

endmodule

// File: tb/tb_key_input_ctrl.sv
// tb/tb_key_input_ctrl.sv - directed self-checking bench for key_input_ctrl with a free-running 20-cycle frame pulse
module tb_key_input_ctrl;
    import tetris_pkg::*;

    localparam int DB    = 4;
    localparam int RD    = 3;
    localparam int RR    = 2;
    localparam int FRAME = 20;

`ifdef KEY_INPUT_AUTOREPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    key_input_ctrl_if keys ();

    key_input_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .REPEAT_MASK     (4'b1110)
    ) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .keys    (keys)
    );

    always #5 vga_clk = ~vga_clk;

    int         compared   = 0;
    int         mismatched = 0;
    int         phase;
    int         win_cnt;
    logic [3:0] win_val;
    logic [3:0] lvl_seen;

    // Frame pulse: one cycle high every FRAME cycles, independent of reset.
    initial begin
        keys.draw_finish = 1'b0;
        phase = 0;
        forever begin
            @(posedge vga_clk);
            #2;
            phase = (phase == FRAME - 1) ? 0 : phase + 1;
            keys.draw_finish = (phase == FRAME - 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of sequence, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
        if (keys.op_keys !== 4'b0000) begin
            win_cnt++;
            win_val |= keys.op_keys;
        end
        lvl_seen |= keys.key_level;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_win();
        win_cnt  = 0;
        win_val  = 4'b0000;
        lvl_seen = 4'b0000;
    endtask

    task automatic end_window(input string tag, input logic [3:0] exp);
        check({tag, "_val"}, 32'(win_val), 32'(exp));
        check({tag, "_width"}, 32'(win_cnt), (exp != 4'b0000) ? 32'd1 : 32'd0);
        clear_win();
    endtask

    initial begin
        int guard;

        keys.key_raw = 4'b0000;
        clear_win();

        // Reset state
        reset = 1'b1;
        ticks(5);
        check("rst_op_keys", 32'(keys.op_keys), 32'd0);
        check("rst_key_level", 32'(keys.key_level), 32'd0);
        reset = 1'b0;

        // Align to the cycle right after draw_finish was sampled
        guard = 0;
        do begin
            tick();
            guard++;
        end while (keys.draw_finish !== 1'b1 && guard < 100);
        check("align_bound", 32'(guard < 100), 32'd1);
        clear_win();

        ticks(FRAME);
        end_window("idle", 4'b0000);

        // Glitch shorter than the debounce window
        keys.key_raw = 4'b0100;
        ticks(3);
        keys.key_raw = 4'b0000;
        ticks(FRAME - 3);
        check("glitch_level", 32'(lvl_seen), 32'd0);
        end_window("glitch", 4'b0000);

        // Clean press: level exactly 6 cycles after the edge, then paced events
        keys.key_raw = 4'b0100;
        ticks(5);
        check("lat_before", 32'(keys.key_level), 32'd0);
        ticks(1);
        check("lat_at", 32'(keys.key_level), 32'b0100);
        ticks(FRAME - 6);
        end_window("pace_w1", 4'b0100);
        for (int w = 2; w <= 10; w++) begin
            ticks(FRAME);
            end_window($sformatf("pace_w%0d", w),
                       (AUTO_REPEAT && (w % 2 == 1)) ? 4'b0100 : 4'b0000);
        end
        keys.key_raw = 4'b0000;
        ticks(FRAME);
        end_window("pace_release", 4'b0000);
        check("pace_level_off", 32'(keys.key_level), 32'd0);

        // Up key never repeats
        keys.key_raw = 4'b0001;
        ticks(FRAME);
        end_window("up_w1", 4'b0001);
        for (int w = 2; w <= 10; w++) begin
            ticks(FRAME);
            end_window($sformatf("up_w%0d", w), 4'b0000);
        end
        keys.key_raw = 4'b0000;
        ticks(FRAME);
        end_window("up_release", 4'b0000);

        // Down and right pressed within one frame collapse into one pulse
        keys.key_raw = 4'b0010;
        ticks(3);
        keys.key_raw = 4'b1010;
        ticks(7);
        keys.key_raw = 4'b0000;
        ticks(FRAME - 10);
        end_window("simul", 4'b1010);
        ticks(FRAME);
        end_window("simul_after", 4'b0000);

        // Event raised in the cycle after draw_finish goes to the following frame
        ticks(14);
        keys.key_raw = 4'b0100;
        ticks(6);
        check("late_level", 32'(keys.key_level), 32'b0100);
        end_window("late_w1", 4'b0000);
        ticks(4);
        keys.key_raw = 4'b0000;
        ticks(FRAME - 4);
        end_window("late_w2", 4'b0100);
        ticks(FRAME);
        end_window("late_w3", 4'b0000);

        // Reset while an event is pending; key held through reset re-presses once
        keys.key_raw = 4'b0100;
        ticks(10);
        reset = 1'b1;
        ticks(1);
        check("rst_mid_level", 32'(keys.key_level), 32'd0);
        check("rst_mid_op", 32'(keys.op_keys), 32'd0);
        ticks(7);
        reset = 1'b0;
        ticks(2);
        end_window("rst_drop", 4'b0000);
        ticks(FRAME);
        end_window("rst_repress", 4'b0100);
        keys.key_raw = 4'b0000;
        ticks(FRAME);
        end_window("rst_release", 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
